// File: rtl/mem_arbiter_if.sv
// Fetch/data requester ports and the shared RAM port of mem_arbiter.
// The arbiter takes the slave view; the requester/RAM side takes the master view.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 31,
    parameter int DATA_WIDTH = 31
);
    logic                  clk_en;

    logic                  i_f_req;
    logic [ADDR_WIDTH:0]   i_f_addr;
    logic                  o_f_gnt;
    logic                  o_f_rvalid;
    logic [DATA_WIDTH:0]   o_f_rdata;

    logic                  i_d_req;
    logic                  i_d_we;
    logic [3:0]            i_d_be;
    logic [ADDR_WIDTH:0]   i_d_addr;
    logic [DATA_WIDTH:0]   i_d_wdata;
    logic                  o_d_gnt;
    logic                  o_d_rvalid;
    logic [DATA_WIDTH:0]   o_d_rdata;

    logic                  o_mem_req;
    logic                  o_mem_we;
    logic [3:0]            o_mem_be;
    logic [ADDR_WIDTH:0]   o_mem_addr;
    logic [DATA_WIDTH:0]   o_mem_wdata;
    logic [DATA_WIDTH:0]   i_mem_rdata;

    modport slave (
        input  clk_en,
        input  i_f_req, i_f_addr,
        output o_f_gnt, o_f_rvalid, o_f_rdata,
        input  i_d_req, i_d_we, i_d_be, i_d_addr, i_d_wdata,
        output o_d_gnt, o_d_rvalid, o_d_rdata,
        output o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata,
        input  i_mem_rdata
    );

    modport master (
        output clk_en,
        output i_f_req, i_f_addr,
        input  o_f_gnt, o_f_rvalid, o_f_rdata,
        output i_d_req, i_d_we, i_d_be, i_d_addr, i_d_wdata,
        input  o_d_gnt, o_d_rvalid, o_d_rdata,
        input  o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata,
        output i_mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-cycle-latency RAM port between a
// fetch (read-only) requester and a data (read/write) requester.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 31,
    parameter int DATA_WIDTH = 31
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_F = 2'd1,
        RESP_D = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   last_gnt_d;   // 1: data was granted last, so fetch wins the next tie
    logic   gnt_f, gnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_gnt_d <= 1'b1;
        end else if (bus.clk_en) begin
            state <= state_nxt;
            if (gnt_f)
                last_gnt_d <= 1'b0;
            else if (gnt_d)
                last_gnt_d <= 1'b1;
        end
    end

    always_comb begin
        gnt_f           = 1'b0;
        gnt_d           = 1'b0;
        state_nxt       = state;
        bus.o_f_rvalid  = 1'b0;
        bus.o_f_rdata   = {(DATA_WIDTH+1){1'b0}};
        bus.o_d_rvalid  = 1'b0;
        bus.o_d_rdata   = {(DATA_WIDTH+1){1'b0}};
        bus.o_mem_req   = 1'b0;
        bus.o_mem_we    = 1'b0;
        bus.o_mem_be    = 4'b0000;
        bus.o_mem_addr  = {(ADDR_WIDTH+1){1'b0}};
        bus.o_mem_wdata = {(DATA_WIDTH+1){1'b0}};

        unique case (state)
            IDLE: begin
                // rst gates grants so the RAM port is quiet while reset is held
                if (rst && bus.clk_en) begin
                    if (bus.i_f_req && bus.i_d_req) begin
                        gnt_f = last_gnt_d;
                        gnt_d = !last_gnt_d;
                    end else begin
                        gnt_f = bus.i_f_req;
                        gnt_d = bus.i_d_req;
                    end
                end
                if (gnt_f) begin
                    bus.o_mem_req  = 1'b1;
                    bus.o_mem_be   = 4'b1111;
                    bus.o_mem_addr = bus.i_f_addr;
                    state_nxt      = RESP_F;
                end else if (gnt_d) begin
                    bus.o_mem_req   = 1'b1;
                    bus.o_mem_we    = bus.i_d_we;
                    bus.o_mem_be    = bus.i_d_be;
                    bus.o_mem_addr  = bus.i_d_addr;
                    bus.o_mem_wdata = bus.i_d_wdata;
                    if (!bus.i_d_we)
                        state_nxt = RESP_D;
                end
            end
            RESP_F: begin
                bus.o_f_rvalid = 1'b1;
                bus.o_f_rdata  = bus.i_mem_rdata;
                state_nxt      = IDLE;
            end
            RESP_D: begin
                bus.o_d_rvalid = 1'b1;
                bus.o_d_rdata  = bus.i_mem_rdata;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.o_f_gnt = gnt_f;
    assign bus.o_d_gnt = gnt_d;
endmodule
